// File: rtl/uart_line_editor.sv
// uart_line_editor: single-row line editor sitting between the UART byte
// receiver and the text engine. Keeps a ROW_CHARS buffer with a cursor,
// handles backspace/CR/LF/ESC, and overlays a blinking cursor on read-out.
module uart_line_editor #(
  parameter int         ROW_CHARS    = 16,
  parameter int         BLINK_CYCLES = 6000000,
  parameter logic [7:0] CURSOR_CHAR  = 8'h5F
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         uartByteReady,
  input  logic [7:0]                   uartDataIn,
  input  logic [$clog2(ROW_CHARS)-1:0] charAddress,
  output logic [7:0]                   charOut,
  output logic [$clog2(ROW_CHARS):0]   cursorPos,
  output logic                         lineDone,
  output logic [$clog2(ROW_CHARS):0]   lineLength,
  output logic                         overflow
);

  localparam int AW = $clog2(ROW_CHARS);
  localparam int CW = $clog2(BLINK_CYCLES + 1);

  localparam logic [AW:0]   ROW_END    = (AW+1)'(ROW_CHARS);
  localparam logic [AW-1:0] LAST_IDX   = AW'(ROW_CHARS - 1);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_DEL   = 8'h7F;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ESC   = 8'h1B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_CLEAR
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    line_q [ROW_CHARS];
  logic [7:0]    line_d [ROW_CHARS];
  logic [AW:0]   cursor_q, cursor_d;
  logic          ready_prev_q;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    pend_byte_q, pend_byte_d;
  logic          clear_pending_q, clear_pending_d;
  logic          last_cr_q, last_cr_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          line_done_q, line_done_d;
  logic [AW:0]   line_len_q, line_len_d;
  logic          overflow_q, overflow_d;
  logic          blink_on_q, blink_on_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic [7:0]    char_out_q, char_out_d;

  logic          byte_event;
  logic          blink_restart;
  logic [AW:0]   cursor_dec;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // A byte is one rising edge of the receiver's level-style valid.
  assign byte_event = uartByteReady && !ready_prev_q;

  // Editor FSM next state: byte decode, clear sweep and the one-entry pending slot.
  always_comb begin
    state_d         = state_q;
    line_d          = line_q;
    cursor_d        = cursor_q;
    rx_byte_d       = rx_byte_q;
    pend_valid_d    = pend_valid_q;
    pend_byte_d     = pend_byte_q;
    clear_pending_d = clear_pending_q;
    last_cr_d       = last_cr_q;
    clr_idx_d       = clr_idx_q;
    line_done_d     = 1'b0;
    line_len_d      = line_len_q;
    overflow_d      = overflow_q;
    blink_restart   = 1'b0;
    cursor_dec      = cursor_q - 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          rx_byte_d    = pend_byte_q;
          pend_valid_d = 1'b0;
          state_d      = S_DECODE;
          if (byte_event) begin
            pend_valid_d = 1'b1;
            pend_byte_d  = uartDataIn;
          end
        end else if (byte_event) begin
          rx_byte_d = uartDataIn;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d       = S_IDLE;
        blink_restart = 1'b1;
        last_cr_d     = (rx_byte_q == CH_CR);
        if (is_printable(rx_byte_q)) begin
          if (clear_pending_q) begin
            if (pend_valid_q) begin
              overflow_d = 1'b1;
            end
            pend_valid_d = 1'b1;
            pend_byte_d  = rx_byte_q;
            clr_idx_d    = '0;
            state_d      = S_CLEAR;
          end else if (cursor_q < ROW_END) begin
            line_d[cursor_q[AW-1:0]] = rx_byte_q;
            cursor_d                 = cursor_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          case (rx_byte_q)
            CH_BS, CH_DEL: begin
              if (!clear_pending_q && (cursor_q != '0)) begin
                cursor_d                   = cursor_dec;
                line_d[cursor_dec[AW-1:0]] = CH_SPACE;
              end
            end
            CH_CR: begin
              line_done_d     = 1'b1;
              line_len_d      = cursor_q;
              clear_pending_d = 1'b1;
            end
            CH_LF: begin
              if (!last_cr_q) begin
                line_done_d     = 1'b1;
                line_len_d      = cursor_q;
                clear_pending_d = 1'b1;
              end
            end
            CH_ESC: begin
              clear_pending_d = 1'b0;
              overflow_d      = 1'b0;
              clr_idx_d       = '0;
              state_d         = S_CLEAR;
            end
            default: begin
            end
          endcase
        end
      end

      S_CLEAR: begin
        line_d[clr_idx_q] = CH_SPACE;
        clr_idx_d         = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          cursor_d        = '0;
          clear_pending_d = 1'b0;
          state_d         = S_IDLE;
          if (pend_valid_q && is_printable(pend_byte_q)) begin
            line_d[0]     = pend_byte_q;
            cursor_d      = 1;
            pend_valid_d  = 1'b0;
            last_cr_d     = 1'b0;
            blink_restart = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bytes arriving while busy go to the pending slot; a full slot drops them.
    if (byte_event && (state_q != S_IDLE)) begin
      if (pend_valid_d) begin
        overflow_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_byte_d  = uartDataIn;
      end
    end
  end

  // Blink timer: free-running half-period counter, restarted visible on input.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (blink_restart) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = !blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  // Read path: buffer lookup with the cursor glyph overlaid during blink-on.
  always_comb begin
    char_out_d = line_q[charAddress];
    if (blink_on_q && ({1'b0, charAddress} == cursor_q) && (cursor_q < ROW_END) &&
        !clear_pending_q && (state_q == S_IDLE)) begin
      char_out_d = CURSOR_CHAR;
    end
  end

  // State registers; reset wipes the line and any partially decoded input.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q         <= S_IDLE;
      for (int i = 0; i < ROW_CHARS; i++) begin
        line_q[i] <= CH_SPACE;
      end
      cursor_q        <= '0;
      ready_prev_q    <= 1'b0;
      rx_byte_q       <= '0;
      pend_valid_q    <= 1'b0;
      pend_byte_q     <= '0;
      clear_pending_q <= 1'b0;
      last_cr_q       <= 1'b0;
      clr_idx_q       <= '0;
      line_done_q     <= 1'b0;
      line_len_q      <= '0;
      overflow_q      <= 1'b0;
      blink_on_q      <= 1'b0;
      blink_cnt_q     <= '0;
      char_out_q      <= CH_SPACE;
    end else begin
      state_q         <= state_d;
      line_q          <= line_d;
      cursor_q        <= cursor_d;
      ready_prev_q    <= uartByteReady;
      rx_byte_q       <= rx_byte_d;
      pend_valid_q    <= pend_valid_d;
      pend_byte_q     <= pend_byte_d;
      clear_pending_q <= clear_pending_d;
      last_cr_q       <= last_cr_d;
      clr_idx_q       <= clr_idx_d;
      line_done_q     <= line_done_d;
      line_len_q      <= line_len_d;
      overflow_q      <= overflow_d;
      blink_on_q      <= blink_on_d;
      blink_cnt_q     <= blink_cnt_d;
      char_out_q      <= char_out_d;
    end
  end

  assign charOut    = char_out_q;
  assign cursorPos  = cursor_q;
  assign lineDone   = line_done_q;
  assign lineLength = line_len_q;
  assign overflow   = overflow_q;

endmodule
